// File: rtl/cbp_adder_rr_scheduler_if.sv
// Request/response bundle for cbp_adder_rr_scheduler.
// resp_ovf exists only when CBP_SCHED_OVF_EN is defined.
`timescale 1ns/1ps
interface cbp_adder_rr_scheduler_if #(
  parameter int NUM_BITS = 32,
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2
) ();
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*NUM_BITS-1:0] req_a;
  logic [NUM_REQ*NUM_BITS-1:0] req_b;
  logic [NUM_REQ-1:0]          req_cin;
  logic                        resp_valid;
  logic                        resp_ready;
  logic [NUM_BITS-1:0]         resp_sum;
  logic                        resp_cout;
  logic [ID_W-1:0]             resp_id;
  logic                        busy;
`ifdef CBP_SCHED_OVF_EN
  logic                        resp_ovf;

  modport master (
    output req_valid, req_a, req_b, req_cin, resp_ready,
    input  req_ready, resp_valid, resp_sum, resp_cout,
    input  resp_id, busy, resp_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, resp_ready,
    output req_ready, resp_valid, resp_sum, resp_cout,
    output resp_id, busy, resp_ovf
  );
`else
  modport master (
    output req_valid, req_a, req_b, req_cin, resp_ready,
    input  req_ready, resp_valid, resp_sum, resp_cout,
    input  resp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, resp_ready,
    output req_ready, resp_valid, resp_sum, resp_cout,
    output resp_id, busy
  );
`endif
endinterface

// File: rtl/cbp_adder_rr_scheduler.sv
// Round-robin scheduler sharing one carry-bypass adder among requesters.
// Define CBP_SCHED_OVF_EN to add the signed-overflow output resp_ovf.
`timescale 1ns/1ps
module cbp_adder_rr_scheduler #(
  parameter int NUM_BITS   = 32,
  parameter int NUM_STAGES = 4,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2
) (
  input logic clk,
  input logic rst_n,
  cbp_adder_rr_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t              state, nxt;
  logic [ID_W-1:0]     rr_ptr, gidx, nptr, id_reg;
  logic [NUM_REQ-1:0]  gnt;
  logic                found;
  logic [NUM_BITS-1:0] sel_a, sel_b, a_reg, b_reg;
  logic                sel_c, cin_reg;
  logic [NUM_BITS-1:0] sum, sum_q;
  logic                cout, cout_q;
  logic [ID_W-1:0]     id_q;
`ifdef CBP_SCHED_OVF_EN
  logic                ovf_q;
`endif

  // Upward search from rr_ptr, then wrap to the low requesters.
  always_comb begin
    gnt   = '0;
    gidx  = '0;
    nptr  = '0;
    found = 1'b0;
    sel_a = '0;
    sel_b = '0;
    sel_c = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.req_valid[i] && i >= int'(rr_ptr)) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        gidx   = ID_W'(i);
        nptr   = ID_W'((i + 1) % NUM_REQ);
        sel_a  = bus.req_a[i*NUM_BITS +: NUM_BITS];
        sel_b  = bus.req_b[i*NUM_BITS +: NUM_BITS];
        sel_c  = bus.req_cin[i];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.req_valid[i]) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        gidx   = ID_W'(i);
        nptr   = ID_W'((i + 1) % NUM_REQ);
        sel_a  = bus.req_a[i*NUM_BITS +: NUM_BITS];
        sel_b  = bus.req_b[i*NUM_BITS +: NUM_BITS];
        sel_c  = bus.req_cin[i];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next state and handshake outputs.
  always_comb begin
    nxt            = state;
    bus.req_ready  = '0;
    bus.resp_valid = 1'b0;
    bus.busy       = 1'b1;
    unique case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (found) begin
          bus.req_ready = gnt;
          nxt           = CALC;
        end
      end
      CALC: nxt = RESP;
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Operand capture on grant, result capture leaving CALC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      cin_reg <= 1'b0;
      id_reg  <= '0;
      rr_ptr  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      id_q    <= '0;
`ifdef CBP_SCHED_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      if (state == IDLE && found) begin
        a_reg   <= sel_a;
        b_reg   <= sel_b;
        cin_reg <= sel_c;
        id_reg  <= gidx;
        rr_ptr  <= nptr;
      end
      if (state == CALC) begin
        sum_q  <= sum;
        cout_q <= cout;
        id_q   <= id_reg;
`ifdef CBP_SCHED_OVF_EN
        ovf_q  <= (a_reg[NUM_BITS-1] == b_reg[NUM_BITS-1]) &&
                  (sum[NUM_BITS-1] != a_reg[NUM_BITS-1]);
`endif
      end
    end
  end

  assign bus.resp_sum  = sum_q;
  assign bus.resp_cout = cout_q;
  assign bus.resp_id   = id_q;
`ifdef CBP_SCHED_OVF_EN
  assign bus.resp_ovf  = ovf_q;
`endif

  CarryBypassAdder #(
    .NUM_BITS   (NUM_BITS),
    .NUM_STAGES (NUM_STAGES)
  ) u_add (
    .a    (a_reg),
    .b    (b_reg),
    .cin  (cin_reg),
    .sum  (sum),
    .cout (cout)
  );

endmodule

module CarryBypassAdder #(
  parameter int NUM_BITS   = 32,
  parameter int NUM_STAGES = 4
) (
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                cin,
  output logic [NUM_BITS-1:0] sum,
  output logic                cout
);

  localparam int BW = NUM_BITS / NUM_STAGES;

  logic c, rc, p;

  // Ripple inside each block; a fully propagating block passes its carry-in.
  always_comb begin
    sum = '0;
    c   = cin;
    rc  = 1'b0;
    p   = 1'b0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      p  = 1'b1;
      rc = c;
      for (int j = 0; j < BW; j++) begin
        p            = p & (a[s*BW+j] ^ b[s*BW+j]);
        sum[s*BW+j]  = a[s*BW+j] ^ b[s*BW+j] ^ rc;
        rc           = (a[s*BW+j] & b[s*BW+j]) |
                       (rc & (a[s*BW+j] ^ b[s*BW+j]));
      end
      c = p ? c : rc;
    end
    cout = c;
  end

endmodule

// File: tb/tb_cbp_adder_rr_scheduler.sv
// Bench for cbp_adder_rr_scheduler: scoreboard of expected results.
// Works with and without CBP_SCHED_OVF_EN.
`timescale 1ns/1ps
module tb_cbp_adder_rr_scheduler;
  localparam int NB = 32;
  localparam int NR = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cbp_adder_rr_scheduler_if #(
    .NUM_BITS(NB), .NUM_REQ(NR), .ID_W(IW)
  ) bus ();

  cbp_adder_rr_scheduler #(
    .NUM_BITS(NB), .NUM_STAGES(4), .NUM_REQ(NR), .ID_W(IW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [NB-1:0] sum;
    logic          cout;
    logic [IW-1:0] id;
    logic          ovf;
  } exp_t;

  exp_t          exp_q[$];
  logic [NB-1:0] op_a [NR];
  logic [NB-1:0] op_b [NR];
  logic          op_c [NR];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_lane(input int i, input logic [NB-1:0] a,
                            input logic [NB-1:0] b, input logic c);
    op_a[i] = a;
    op_b[i] = b;
    op_c[i] = c;
    bus.req_a[i*NB +: NB] = a;
    bus.req_b[i*NB +: NB] = b;
    bus.req_cin[i] = c;
  endtask

  task automatic push_exp(input int i);
    exp_t e;
    logic [NB:0] full;
    full = {1'b0, op_a[i]} + {1'b0, op_b[i]} + {{NB{1'b0}}, op_c[i]};
    e.sum  = full[NB-1:0];
    e.cout = full[NB];
    e.id   = IW'(i);
`ifdef CBP_SCHED_OVF_EN
    e.ovf  = (op_a[i][NB-1] == op_b[i][NB-1]) &&
             (e.sum[NB-1] != op_a[i][NB-1]);
`else
    e.ovf  = 1'b0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic pop_exp(output exp_t e, output bit ok);
    ok = exp_q.size() > 0;
    e = '0;
    if (ok) e = exp_q.pop_front();
  endtask

  function automatic exp_t get_obs();
    exp_t o;
    o.sum  = bus.resp_sum;
    o.cout = bus.resp_cout;
    o.id   = bus.resp_id;
`ifdef CBP_SCHED_OVF_EN
    o.ovf  = bus.resp_ovf;
`else
    o.ovf  = 1'b0;
`endif
    return o;
  endfunction

  task automatic wait_grant(output bit got);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (|bus.req_ready) got = 1'b1;
    end
  endtask

  task automatic wait_resp(output bit got);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [NB+NR+IW+2:0] v;
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_cin = '0;
    bus.resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    v = {bus.req_ready, bus.resp_valid, bus.resp_sum,
         bus.resp_cout, bus.resp_id, bus.busy};
    n_cmp++;
    if (v !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0", v);
    end
`ifdef CBP_SCHED_OVF_EN
    n_cmp++;
    if (bus.resp_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ovf: got %b want 0", bus.resp_ovf);
    end
`endif
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    exp_t e, o;
    bit ok;
    step();
    drive_lane(0, 32'hFFFF_FFFF, 32'h1, 1'b0);
    bus.req_valid = 4'b0001;
    bus.resp_ready = 1'b1;
    push_exp(0);
    @(negedge clk);
    n_cmp++;
    if (bus.req_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL single_grant: got %b want 0001", bus.req_ready);
    end
    step();
    bus.req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if ({bus.resp_valid, bus.busy, bus.req_ready} !== 6'b010000) begin
      n_bad++;
      $display("FAIL single_calc: got v=%b busy=%b rdy=%b want 0/1/0000",
               bus.resp_valid, bus.busy, bus.req_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.resp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL single_latency: got valid %b want 1", bus.resp_valid);
    end
    o = get_obs();
    pop_exp(e, ok);
    n_cmp++;
    if (!ok || o !== e || o.sum !== 32'h0 || o.cout !== 1'b1) begin
      n_bad++;
      $display("FAIL single_data: got %h want %h (sum 0 cout 1)", o, e);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.resp_valid, bus.busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL single_release: got v=%b busy=%b want 0/0",
               bus.resp_valid, bus.busy);
    end
  endtask

  task automatic test_round_robin();
    exp_t e, o;
    bit ok, got;
    int prev;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) drive_lane(i, NB'(i), NB'(10 * i), 1'b0);
    bus.req_valid = 4'hF;
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) push_exp(k % NR);
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_resp(got);
      o = get_obs();
      pop_exp(e, ok);
      n_cmp++;
      if (!got || !ok || o !== e || o.sum !== NB'(11 * (k % NR))) begin
        n_bad++;
        $display("FAIL rr_resp%0d: got %h (valid %b) want %h",
                 k, o, got, e);
      end
      if (k > 0) begin
        n_cmp++;
        if (cyc - prev !== 3) begin
          n_bad++;
          $display("FAIL rr_spacing%0d: got %0d want 3", k, cyc - prev);
        end
      end
      prev = cyc;
    end
    step();
    bus.req_valid = '0;
  endtask

  task automatic test_backpressure();
    exp_t e, o0;
    bit ok, got;
    step();
    drive_lane(2, $urandom, $urandom, 1'b1);
    bus.req_valid = 4'b0100;
    bus.resp_ready = 1'b0;
    push_exp(2);
    wait_grant(got);
    n_cmp++;
    if (!got || bus.req_ready !== 4'b0100) begin
      n_bad++;
      $display("FAIL bp_grant: got %b want 0100", bus.req_ready);
    end
    step();
    bus.req_valid = '0;
    wait_resp(got);
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL bp_resp: got no resp_valid want 1");
    end
    o0 = get_obs();
    step();
    bus.req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (get_obs() !== o0 || bus.resp_valid !== 1'b1 ||
          bus.busy !== 1'b1 || bus.req_ready !== 4'b0000) begin
        n_bad++;
        $display("FAIL bp_stall%0d: got %h v=%b busy=%b rdy=%b want %h 1/1/0",
                 k, get_obs(), bus.resp_valid, bus.busy,
                 bus.req_ready, o0);
      end
    end
    step();
    bus.resp_ready = 1'b1;
    bus.req_valid = '0;
    pop_exp(e, ok);
    n_cmp++;
    if (!ok || o0 !== e) begin
      n_bad++;
      $display("FAIL bp_data: got %h want %h", o0, e);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.resp_valid, bus.busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL bp_release: got v=%b busy=%b want 0/0",
               bus.resp_valid, bus.busy);
    end
  endtask

  task automatic test_pointer_skip();
    exp_t e, o;
    bit ok, got;
    logic [NR-1:0] want [3];
    logic [NR-1:0] after [3];
    want[0] = 4'b0010; after[0] = 4'b0000;
    want[1] = 4'b1000; after[1] = 4'b0001;
    want[2] = 4'b0001; after[2] = 4'b0000;
    step();
    drive_lane(1, $urandom, $urandom, 1'b0);
    bus.req_valid = 4'b0010;
    bus.resp_ready = 1'b1;
    push_exp(1);
    for (int k = 0; k < 3; k++) begin
      wait_grant(got);
      n_cmp++;
      if (!got || bus.req_ready !== want[k]) begin
        n_bad++;
        $display("FAIL skip_grant%0d: got %b want %b",
                 k, bus.req_ready, want[k]);
      end
      step();
      if (k == 0) begin
        drive_lane(0, $urandom, $urandom, 1'b1);
        drive_lane(3, $urandom, $urandom, 1'b0);
        push_exp(3);
        push_exp(0);
      end
      bus.req_valid = after[k];
      wait_resp(got);
      o = get_obs();
      pop_exp(e, ok);
      n_cmp++;
      if (!got || !ok || o !== e) begin
        n_bad++;
        $display("FAIL skip_resp%0d: got %h want %h", k, o, e);
      end
      if (k == 0) begin
        step();
        bus.req_valid = 4'b1001;
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e, o;
    bit ok, got;
    logic [NR+NB+IW+2:0] v;
    step();
    drive_lane(0, $urandom, $urandom, 1'b0);
    bus.req_valid = 4'b0001;
    wait_grant(got);
    n_cmp++;
    if (!got || bus.req_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL arst_pre_grant: got %b want 0001", bus.req_ready);
    end
    step();
    bus.req_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    v = {bus.req_ready, bus.resp_valid, bus.resp_sum,
         bus.resp_cout, bus.resp_id, bus.busy};
    n_cmp++;
    if (v !== '0) begin
      n_bad++;
      $display("FAIL arst_outputs: got %h want 0", v);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.resp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL arst_no_resp: got %b want 0", bus.resp_valid);
    end
    step();
    rst_n = 1'b1;
    drive_lane(0, $urandom, $urandom, 1'b1);
    drive_lane(2, $urandom, $urandom, 1'b0);
    bus.req_valid = 4'b0101;
    push_exp(0);
    wait_grant(got);
    n_cmp++;
    if (!got || bus.req_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL arst_ptr: got %b want 0001", bus.req_ready);
    end
    step();
    bus.req_valid = '0;
    wait_resp(got);
    o = get_obs();
    pop_exp(e, ok);
    n_cmp++;
    if (!got || !ok || o !== e) begin
      n_bad++;
      $display("FAIL arst_resp0: got %h want %h", o, e);
    end
    step();
    bus.req_valid = 4'b0100;
    push_exp(2);
    wait_grant(got);
    n_cmp++;
    if (!got || bus.req_ready !== 4'b0100) begin
      n_bad++;
      $display("FAIL arst_grant2: got %b want 0100", bus.req_ready);
    end
    step();
    bus.req_valid = '0;
    wait_resp(got);
    o = get_obs();
    pop_exp(e, ok);
    n_cmp++;
    if (!got || !ok || o !== e) begin
      n_bad++;
      $display("FAIL arst_resp2: got %h want %h", o, e);
    end
  endtask

  task automatic test_arith();
    exp_t e, o;
    bit ok, got;
    logic [NB-1:0] ta [6];
    logic [NB-1:0] tb_ [6];
    logic          tc [6];
    ta[0] = 32'h7FFF_FFFF; tb_[0] = 32'h1;          tc[0] = 1'b0;
    ta[1] = 32'h8000_0000; tb_[1] = 32'h8000_0000; tc[1] = 1'b0;
    ta[2] = 32'hFFFF_FFFF; tb_[2] = 32'h0;          tc[2] = 1'b1;
    ta[3] = 32'h0000_FFFF; tb_[3] = 32'h0;          tc[3] = 1'b1;
    ta[4] = 32'h00FF_00FF; tb_[4] = 32'hFF00_FF00; tc[4] = 1'b1;
    ta[5] = $urandom;      tb_[5] = $urandom;      tc[5] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      drive_lane(3, ta[k], tb_[k], tc[k]);
      bus.req_valid = 4'b1000;
      push_exp(3);
      wait_grant(got);
      step();
      bus.req_valid = '0;
      wait_resp(got);
      o = get_obs();
      pop_exp(e, ok);
      n_cmp++;
      if (!got || !ok || o !== e) begin
        n_bad++;
        $display("FAIL arith%0d: got %h want %h", k, o, e);
      end
      if (k == 0) begin
        n_cmp++;
`ifdef CBP_SCHED_OVF_EN
        if (o.sum !== 32'h8000_0000 || o.cout !== 1'b0 || o.ovf !== 1'b1) begin
`else
        if (o.sum !== 32'h8000_0000 || o.cout !== 1'b0) begin
`endif
          n_bad++;
          $display("FAIL ovf_case: got sum %h cout %b ovf %b want 80000000 0 1",
                   o.sum, o.cout, o.ovf);
        end
      end
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL queue_drain: got %0d left want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_pointer_skip();
    test_async_reset();
    test_arith();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cbp_adder_rr_scheduler.md
Name: cbp_adder_rr_scheduler

Overview:
- Shares one CarryBypassAdder instance, combinational, NUM_BITS wide, between NUM_REQ requesters.
- Arbitration is round-robin.
- Operands of the granted request are registered, the adder computes, and the sum is registered.
- The result goes back over a valid/ready response channel tagged with the requester ID.
- Sits between the per-lane issue logic and the shared arithmetic resource; exactly one operation is in flight at a time.

Parameters:
- NUM_BITS, 32, operand/sum width; must be divisible by NUM_STAGES.
- NUM_STAGES, 4, bypass stages passed to the adder instance.
- NUM_REQ, 4, number of requesters; range 2..16.
- ID_W, 2, width of the requester ID; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant/accept, one-hot or zero.
- req_a  in  NUM_REQ*NUM_BITS  operand A; requester i occupies slice [i*NUM_BITS +: NUM_BITS].
- req_b  in  NUM_REQ*NUM_BITS  operand B, same packing as req_a.
- req_cin  in  NUM_REQ  carry-in per requester.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_sum  out  NUM_BITS  registered sum.
- resp_cout  out  1  registered carry-out.
- resp_id  out  ID_W  index of the requester that owns the result.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n low, asynchronous) forces the following:
  - state=IDLE, rr_ptr=0.
  - req_ready=0, resp_valid=0, resp_sum=0, resp_cout=0, resp_id=0, busy=0.
  - Operand registers cleared.
- Reset mid-operation discards the in-flight operation; no response is produced.
- FSM has three states: IDLE, CALC, RESP.
- IDLE:
  - If any req_valid bit is set, the grant is combinational. Pick the first asserted bit searching upward from rr_ptr with wrap-around.
  - Assert req_ready[g] for that cycle only.
  - On the edge: capture req_a/req_b/req_cin slice g into the operand regs, set id_reg=g, set rr_ptr=(g+1) mod NUM_REQ, go to CALC.
  - No valid bits set: stay in IDLE, req_ready=0.
- CALC:
  - The adder sees the operand regs.
  - On the edge: resp_sum<=Sum, resp_cout<=Cout, resp_id<=id_reg; go to RESP.
  - req_ready=0.
- RESP:
  - resp_valid=1.
  - resp_sum, resp_cout and resp_id are stable until resp_ready=1.
  - On resp_valid&&resp_ready, go to IDLE; resp_valid drops the next cycle.
  - req_ready=0 throughout.
- Timing:
  - Latency: a grant at edge T gives resp_valid high in cycle T+2.
  - Maximum throughput is one operation per 3 cycles when resp_ready is tied high.
- Arithmetic: {resp_cout, resp_sum} = A + B + Cin, modulo 2^(NUM_BITS+1); no saturation.
- Boundary conditions:
  - All requesters valid: grants rotate 0,1,2,3,0...
  - A requester that drops valid before being granted loses nothing; no state is kept for it.
  - Held resp_ready=0 stalls indefinitely with outputs stable.
  - req_valid with req_ready=0 must be held by the requester; the scheduler never accepts outside IDLE.
  - rr_ptr wraps from NUM_REQ-1 to 0.

Optional Feature:
- Macro: CBP_SCHED_OVF_EN.
- When defined:
  - Extra output resp_ovf (1 bit) is registered in CALC as the two's-complement signed overflow: (A[MSB]==B[MSB]) && (Sum[MSB]!=A[MSB]).
  - resp_ovf resets to 0 and is valid alongside resp_valid.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Single request: req_valid=4'b0001, A=32'hFFFF_FFFF, B=1, cin=0 -> req_ready[0] for 1 cycle; 2 cycles later resp_valid=1, sum=0, cout=1, id=0.
- Round-robin: all 4 valid continuously, A=i, B=10*i, resp_ready=1 -> resp_id sequence 0,1,2,3,0 with sums 0,11,22,33; responses 3 cycles apart.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP -> outputs stable, req_ready stays 0, busy=1; the handshake then returns to IDLE.
- Pointer skip: after a grant to 1, only req_valid[0] and req_valid[3] set -> grant 3 first, then 0.
- Async reset: assert rst_n=0 during CALC -> all outputs 0 immediately; after release, rr_ptr=0 and a new request to requester 2 is served normally.
- CBP_SCHED_OVF_EN: A=32'h7FFF_FFFF, B=1, cin=0 -> sum=32'h8000_0000, resp_ovf=1, cout=0.
